mips_run_ctrl: RTL and testbench

//  Synthesizable run controller that gates the MIPS datapath clock enable and replaces hand-toggled clock stimulus.
//  A host issues commands: run N cycles, free-run, halt, clear counter.
//  It counts executed cycles, honours a datapath break request and reports completion with a stop reason.

---
 rtl/mips_run_ctrl_pkg.sv | 22 ++
 rtl/mips_run_ctrl_if.sv | 12 +
 rtl/mips_run_ctrl_sat_counter.sv | 22 ++
 rtl/mips_run_ctrl.sv | 105 ++++++++++
 tb/tb_mips_run_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_run_ctrl_pkg.sv
// Shared op, stop-reason and state encodings for the MIPS run controller.
package mips_dbg_pkg;

  localparam logic [1:0] OP_RUN_N = 2'b00;
  localparam logic [1:0] OP_FREE  = 2'b01;
  localparam logic [1:0] OP_HALT  = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic [1:0] RSN_COUNT = 2'd0;
  localparam logic [1:0] RSN_HALT  = 2'd1;
  localparam logic [1:0] RSN_BRK   = 2'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FREE = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  function automatic logic is_exec(input logic [1:0] s);
    return (s == S_RUN) || (s == S_FREE);
  endfunction

endpackage

// File: rtl/mips_run_ctrl_if.sv
// Host command channel of the run controller (valid/ready handshake).
interface mips_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_count;

  modport master (output cmd_valid, output cmd_op, output cmd_count, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_count, output cmd_ready);
endinterface

// File: rtl/mips_run_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run controller gating the MIPS datapath clock enable from host commands.
module mips_run_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_run_ctrl_if.slave   cmd,
  input  logic             brk_in,
  output logic             cpu_en,
  output logic             busy,
  output logic             done,
  output logic [1:0]       stop_reason,
  output logic             cmd_err,
  output logic [CYC_W-1:0] cycle_count
);

  logic [1:0]       state, state_nxt;
  logic [1:0]       rsn_nxt;
  logic [CNT_W-1:0] remaining, rem_nxt;
  logic             accept;
  logic             err_nxt;
  logic             clr_cnt;

  assign cmd.cmd_ready = (state != S_DONE);
  assign accept        = cmd.cmd_valid & cmd.cmd_ready;

  always_comb begin
    state_nxt = state;
    rem_nxt   = remaining;
    rsn_nxt   = stop_reason;
    err_nxt   = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (cmd.cmd_op)
            OP_RUN_N: begin
              if (cmd.cmd_count == '0) begin
                state_nxt = S_DONE;
                rsn_nxt   = RSN_COUNT;
              end else begin
                state_nxt = S_RUN;
                rem_nxt   = cmd.cmd_count;
              end
            end
            OP_FREE: state_nxt = S_FREE;
            OP_CLR:  clr_cnt   = 1'b1;
            default: ;
          endcase
        end
      end
      S_RUN, S_FREE: begin
        if (accept && (cmd.cmd_op != OP_HALT)) err_nxt = 1'b1;
        if (state == S_RUN && cpu_en) rem_nxt = remaining - 1'b1;
        // Stop causes in priority order: host HALT, break, count exhausted.
        if (accept && (cmd.cmd_op == OP_HALT)) begin
          state_nxt = S_DONE;
          rsn_nxt   = RSN_HALT;
          rem_nxt   = '0;
        end else if (cpu_en && brk_in) begin
          state_nxt = S_DONE;
          rsn_nxt   = RSN_BRK;
          rem_nxt   = '0;
        end else if (state == S_RUN && remaining == CNT_W'(1)) begin
          state_nxt = S_DONE;
          rsn_nxt   = RSN_COUNT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state, so cpu_en/busy/done line up with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      remaining   <= '0;
      stop_reason <= RSN_COUNT;
      cpu_en      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      state       <= state_nxt;
      remaining   <= rem_nxt;
      stop_reason <= rsn_nxt;
      cpu_en      <= is_exec(state_nxt);
      busy        <= is_exec(state_nxt);
      done        <= (state_nxt == S_DONE);
      cmd_err     <= err_nxt;
    end
  end

  sat_counter #(.W(CYC_W)) u_cyc_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cpu_en),
    .clr   (clr_cnt),
    .count (cycle_count)
  );

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed self-checking bench for mips_run_ctrl (main instance plus a CYC_W=4 instance).
module tb_mips_run_ctrl;
  import mips_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        brk_in = 1'b0;
  logic        cpu_en, busy, done, cmd_err;
  logic [1:0]  stop_reason;
  logic [31:0] cycle_count;

  logic        cpu_en4, busy4, done4, cmd_err4;
  logic [1:0]  stop_reason4;
  logic [3:0]  cycle_count4;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mips_run_ctrl_if #(.CNT_W(16)) hif ();
  mips_run_ctrl_if #(.CNT_W(16)) hif4 ();

  mips_run_ctrl #(.CNT_W(16), .CYC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(hif.slave), .brk_in(brk_in),
    .cpu_en(cpu_en), .busy(busy), .done(done), .stop_reason(stop_reason),
    .cmd_err(cmd_err), .cycle_count(cycle_count)
  );

  mips_run_ctrl #(.CNT_W(16), .CYC_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd(hif4.slave), .brk_in(1'b0),
    .cpu_en(cpu_en4), .busy(busy4), .done(done4), .stop_reason(stop_reason4),
    .cmd_err(cmd_err4), .cycle_count(cycle_count4)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic send(input logic [1:0] op, input logic [15:0] cnt);
    hif.cmd_valid = 1'b1;
    hif.cmd_op    = op;
    hif.cmd_count = cnt;
    @(negedge clk);
    hif.cmd_valid = 1'b0;
  endtask

  task automatic send4(input logic [1:0] op);
    hif4.cmd_valid = 1'b1;
    hif4.cmd_op    = op;
    hif4.cmd_count = '0;
    @(negedge clk);
    hif4.cmd_valid = 1'b0;
  endtask

  // Counts enabled cycles from the current negedge until done is seen (bounded).
  task automatic run_observe(input string tag, output int unsigned en);
    bit seen = 0;
    en = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1;
      else begin
        if (cpu_en) en++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 1);
  endtask

  int unsigned en_cnt;

  initial begin
    hif.cmd_valid = 1'b0; hif.cmd_op = OP_HALT; hif.cmd_count = '0;
    hif4.cmd_valid = 1'b0; hif4.cmd_op = OP_HALT; hif4.cmd_count = '0;
    #23;
    check("rst_cpu_en", 32'(cpu_en), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_cmd_err", 32'(cmd_err), 0);
    check("rst_reason", 32'(stop_reason), 0);
    check("rst_count", cycle_count, 0);
    check("rst_ready", 32'(hif.cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // RUN_N 5
    send(OP_RUN_N, 16'd5);
    check("run5_busy", 32'(busy), 1);
    run_observe("run5", en_cnt);
    check("run5_en_cycles", en_cnt, 5);
    check("run5_reason", 32'(stop_reason), 0);
    check("run5_count", cycle_count, 5);
    check("run5_ready_done", 32'(hif.cmd_ready), 0);
    check("run5_busy_done", 32'(busy), 0);
    @(negedge clk);
    check("run5_done_pulse", 32'(done), 0);

    // RUN_N 0
    send(OP_RUN_N, 16'd0);
    check("run0_done", 32'(done), 1);
    check("run0_cpu_en", 32'(cpu_en), 0);
    check("run0_reason", 32'(stop_reason), 0);
    @(negedge clk);
    check("run0_cpu_en2", 32'(cpu_en), 0);
    check("run0_count", cycle_count, 5);

    // CLR in IDLE, then FREE halted after 7 enabled cycles
    send(OP_CLR, 16'd0);
    check("clr_idle_count", cycle_count, 0);
    send(OP_FREE, 16'd0);
    repeat (6) @(negedge clk);
    check("free_cpu_en", 32'(cpu_en), 1);
    send(OP_HALT, 16'd0);
    check("halt_done", 32'(done), 1);
    check("halt_cpu_en", 32'(cpu_en), 0);
    check("halt_reason", 32'(stop_reason), 1);
    check("halt_count", cycle_count, 7);
    @(negedge clk);

    // Break on third enabled cycle
    send(OP_CLR, 16'd0);
    send(OP_FREE, 16'd0);
    repeat (2) @(negedge clk);
    brk_in = 1'b1;
    @(negedge clk);
    brk_in = 1'b0;
    check("brk_done", 32'(done), 1);
    check("brk_reason", 32'(stop_reason), 2);
    check("brk_count", cycle_count, 3);
    @(negedge clk);

    // HALT and break on the same edge: HALT wins
    send(OP_FREE, 16'd0);
    brk_in = 1'b1;
    send(OP_HALT, 16'd0);
    brk_in = 1'b0;
    check("prio_done", 32'(done), 1);
    check("prio_reason", 32'(stop_reason), 1);
    @(negedge clk);

    // Dropped commands mid-run
    send(OP_CLR, 16'd0);
    send(OP_RUN_N, 16'd10);
    repeat (2) @(negedge clk);
    send(OP_RUN_N, 16'd3);
    check("drop_run_err", 32'(cmd_err), 1);
    send(OP_CLR, 16'd0);
    check("drop_clr_err", 32'(cmd_err), 1);
    check("drop_clr_count", cycle_count, 4);
    run_observe("run10", en_cnt);
    check("run10_rest_en", en_cnt, 6);
    check("run10_reason", 32'(stop_reason), 0);
    check("run10_count", cycle_count, 10);
    @(negedge clk);
    check("run10_err_clear", 32'(cmd_err), 0);
    send(OP_CLR, 16'd0);
    check("clr_idle2_count", cycle_count, 0);

    // HALT in IDLE is a silent no-op
    send(OP_HALT, 16'd0);
    check("idle_halt_err", 32'(cmd_err), 0);
    check("idle_halt_done", 32'(done), 0);
    check("idle_halt_busy", 32'(busy), 0);

    // Saturation with CYC_W=4
    send4(OP_FREE);
    repeat (20) @(negedge clk);
    check("sat_count", 32'(cycle_count4), 15);
    check("sat_cpu_en", 32'(cpu_en4), 1);
    send4(OP_HALT);
    check("sat_done", 32'(done4), 1);
    check("sat_count_hold", 32'(cycle_count4), 15);
    @(negedge clk);

    // Async reset mid-FREE
    send(OP_FREE, 16'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cpu_en", 32'(cpu_en), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_count", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("arst_no_done", 32'(done), 0);
    end
    check("arst_ready", 32'(hif.cmd_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
